// File: rtl/mmac_tile_engine_if.sv
// Operand/result handshake bundle for mmac_tile_engine.
interface mmac_tile_engine_if #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int AW = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [N*N*DW-1:0]   mat_a;
  logic [N*N*DW-1:0]   mat_b;
  logic                acc_mode;
  logic                clear;
  logic                out_valid;
  logic                out_ready;
  logic [N*N*AW-1:0]   res;
  logic                busy;
  logic                ovf;

  modport master (
    output in_valid, mat_a, mat_b, acc_mode, clear, out_ready,
    input  in_ready, out_valid, res, busy, ovf
  );

  modport slave (
    input  in_valid, mat_a, mat_b, acc_mode, clear, out_ready,
    output in_ready, out_valid, res, busy, ovf
  );
endinterface

// File: rtl/mmac_tile_engine.sv
// NxN unsigned matrix multiply-accumulate engine: one result element per cycle,
// row-major, with a sticky overflow flag and overwrite/accumulate modes.
module mmac_tile_engine #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int AW = 32
) (
  input logic               clk,
  input logic               rst,
  mmac_tile_engine_if.slave bus
);

  localparam int CW = $clog2(N);
  localparam int IW = $clog2(N*N);
  localparam int SW = 2*DW + $clog2(N) + 1;
  localparam int EW = ((AW > SW) ? AW : SW) + 1;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_e;

  state_e              state_q, state_d;
  logic [N*N*DW-1:0]   a_q, a_d, b_q, b_d;
  logic                mode_q, mode_d;
  logic [CW-1:0]       i_q, i_d, j_q, j_d;
  logic                iss_q, iss_d;
  logic                wb_vld_q, wb_vld_d;
  logic                wb_last_q, wb_last_d;
  logic [IW-1:0]       wb_idx_q, wb_idx_d;
  logic [SW-1:0]       dot_q, dot_d;
  logic [N*N*AW-1:0]   acc_q, acc_d;
  logic                ovf_q, ovf_d;

  logic [SW-1:0]       dot_c;
  logic [AW-1:0]       acc_old;
  logic [EW-1:0]       sum_c;

  always_comb begin
    dot_c = '0;
    for (int unsigned k = 0; k < N; k++) begin
      dot_c = dot_c + SW'(a_q[(32'(i_q)*N + k)*DW +: DW])
                    * SW'(b_q[(k*N + 32'(j_q))*DW +: DW]);
    end
  end

  // Extra bit above the accumulator width exposes the carry used for ovf.
  assign acc_old = acc_q[32'(wb_idx_q)*AW +: AW];
  assign sum_c   = (mode_q ? EW'(acc_old) : '0) + EW'(dot_q);

  // Two-stage issue/writeback: the dot product is registered before it is
  // added, so COMPUTE spans N*N+1 cycles and DONE follows the last writeback.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    mode_d    = mode_q;
    i_d       = i_q;
    j_d       = j_q;
    iss_d     = iss_q;
    wb_vld_d  = 1'b0;
    wb_last_d = 1'b0;
    wb_idx_d  = wb_idx_q;
    dot_d     = dot_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (bus.clear) begin
          acc_d = '0;
          ovf_d = 1'b0;
        end
        if (bus.in_valid) begin
          a_d     = bus.mat_a;
          b_d     = bus.mat_b;
          mode_d  = bus.acc_mode;
          i_d     = '0;
          j_d     = '0;
          iss_d   = 1'b1;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        if (iss_q) begin
          dot_d     = dot_c;
          wb_vld_d  = 1'b1;
          wb_idx_d  = IW'(32'(i_q)*N + 32'(j_q));
          wb_last_d = (i_q == CW'(N-1)) && (j_q == CW'(N-1));
          if (j_q == CW'(N-1)) begin
            j_d = '0;
            i_d = i_q + 1'b1;
          end else begin
            j_d = j_q + 1'b1;
          end
          if (wb_last_d) begin
            i_d   = '0;
            iss_d = 1'b0;
          end
        end
        if (wb_vld_q) begin
          acc_d[32'(wb_idx_q)*AW +: AW] = sum_c[AW-1:0];
          if (sum_c[EW-1:AW] != '0) ovf_d = 1'b1;
          if (wb_last_q) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.clear) begin
          acc_d = '0;
          ovf_d = 1'b0;
        end
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= 1'b0;
      i_q       <= '0;
      j_q       <= '0;
      iss_q     <= 1'b0;
      wb_vld_q  <= 1'b0;
      wb_last_q <= 1'b0;
      wb_idx_q  <= '0;
      dot_q     <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mode_q    <= mode_d;
      i_q       <= i_d;
      j_q       <= j_d;
      iss_q     <= iss_d;
      wb_vld_q  <= wb_vld_d;
      wb_last_q <= wb_last_d;
      wb_idx_q  <= wb_idx_d;
      dot_q     <= dot_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == COMPUTE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.res       = acc_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_mmac_tile_engine.sv
// Scoreboard bench: two engines (AW=32 and AW=16) driven in lockstep from one
// operand stream, each result checked against a reference matrix model.
module tb_mmac_tile_engine;
  localparam int N  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic acc_mode = 1'b0;
  logic clear = 1'b0;
  logic out_ready = 1'b0;
  logic [N*N*DW-1:0] mat_a = '0;
  logic [N*N*DW-1:0] mat_b = '0;

  always #5 clk = ~clk;

  mmac_tile_engine_if #(.N(N), .DW(DW), .AW(32)) bus32 ();
  mmac_tile_engine_if #(.N(N), .DW(DW), .AW(16)) bus16 ();

  assign bus32.in_valid  = in_valid;
  assign bus32.mat_a     = mat_a;
  assign bus32.mat_b     = mat_b;
  assign bus32.acc_mode  = acc_mode;
  assign bus32.clear     = clear;
  assign bus32.out_ready = out_ready;
  assign bus16.in_valid  = in_valid;
  assign bus16.mat_a     = mat_a;
  assign bus16.mat_b     = mat_b;
  assign bus16.acc_mode  = acc_mode;
  assign bus16.clear     = clear;
  assign bus16.out_ready = out_ready;

  mmac_tile_engine #(.N(N), .DW(DW), .AW(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));
  mmac_tile_engine #(.N(N), .DW(DW), .AW(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));

  typedef struct {
    logic [511:0] r32;
    logic [255:0] r16;
    logic         o32;
    logic         o16;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int unsigned ma[16];
  int unsigned mb[16];
  longint unsigned m32[16];
  longint unsigned m16[16];
  bit o32 = 1'b0;
  bit o16 = 1'b0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_zero();
    for (int e = 0; e < 16; e++) begin
      m32[e] = 0;
      m16[e] = 0;
    end
    o32 = 1'b0;
    o16 = 1'b0;
  endtask

  task automatic model_op(input bit mode, input bit clr);
    exp_t x;
    longint unsigned dot, v32, v16;
    if (clr) model_zero();
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        dot = 0;
        for (int k = 0; k < 4; k++) dot += longint'(ma[i*4+k]) * longint'(mb[k*4+j]);
        v32 = (mode ? m32[i*4+j] : 0) + dot;
        v16 = (mode ? m16[i*4+j] : 0) + dot;
        if (v32 > 64'hFFFF_FFFF) o32 = 1'b1;
        if (v16 > 64'hFFFF) o16 = 1'b1;
        m32[i*4+j] = v32 & 64'hFFFF_FFFF;
        m16[i*4+j] = v16 & 64'hFFFF;
      end
    end
    for (int e = 0; e < 16; e++) begin
      x.r32[e*32 +: 32] = m32[e][31:0];
      x.r16[e*16 +: 16] = m16[e][15:0];
    end
    x.o32 = o32;
    x.o16 = o16;
    sb.push_back(x);
  endtask

  task automatic set_mats(input int unsigned av, input bit a_ident, input int unsigned bv, input bit rnd);
    for (int e = 0; e < 16; e++) begin
      if (rnd) begin
        ma[e] = $urandom_range(0, 255);
        mb[e] = $urandom_range(0, 255);
      end else begin
        ma[e] = a_ident ? ((e / 4 == e % 4) ? 1 : 0) : av;
        mb[e] = bv;
      end
    end
  endtask

  task automatic accept(input bit mode, input bit clr);
    int cyc = 0;
    logic [7:0] t;
    for (int e = 0; e < 16; e++) begin
      t = ma[e][7:0]; mat_a[e*8 +: 8] = t;
      t = mb[e][7:0]; mat_b[e*8 +: 8] = t;
    end
    acc_mode = mode;
    clear    = clr;
    in_valid = 1'b1;
    while (bus32.in_ready !== 1'b1 && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    if (cyc >= 50) check("accept_wait", bus32.in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    clear    = 1'b0;
    model_op(mode, clr);
    check("busy_after_accept", bus32.busy, 1);
    check("in_ready_in_compute", bus32.in_ready, 0);
    mat_a = ~mat_a;
    mat_b = {4{$urandom()}};
    acc_mode = ~mode;
  endtask

  task automatic collect(input int lat, input int hold);
    int cyc = 0;
    exp_t x;
    while (bus32.out_valid !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    check("latency", cyc, lat);
    if (sb.size() == 0) begin
      check("scoreboard_empty", sb.size(), 1);
      return;
    end
    x = sb.pop_front();
    check("res32", bus32.res, x.r32);
    check("res16", bus16.res, x.r16);
    check("ovf32", bus32.ovf, x.o32);
    check("ovf16", bus16.ovf, x.o16);
    check("in_ready_done", bus32.in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_out_valid", bus32.out_valid, 1);
      check("hold_in_ready", bus32.in_ready, 0);
      check("hold_res32", bus32.res, x.r32);
    end
  endtask

  task automatic release_result(input bit clr);
    if (clr) begin
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      model_zero();
      check("clr_done_res32", bus32.res, 0);
      check("clr_done_res16", bus16.res, 0);
      check("clr_done_ovf16", bus16.ovf, 0);
      check("clr_done_out_valid", bus32.out_valid, 1);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("release_in_ready", bus32.in_ready, 1);
    check("release_out_valid", bus32.out_valid, 0);
    check("release_no_accept", bus32.busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] e32;
    logic [15:0] e16;
    model_zero();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus32.in_ready, 1);
    check("rst_out_valid", bus32.out_valid, 0);
    check("rst_busy", bus32.busy, 0);
    check("rst_ovf", bus32.ovf, 0);
    check("rst_res32", bus32.res, 0);
    check("rst_res16", bus16.res, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    set_mats(0, 1'b1, 3, 1'b0);
    accept(1'b0, 1'b0);
    collect(17, 5);
    release_result(1'b0);
    e32 = bus32.res[31:0];
    check("ident_b3", e32, 3);

    accept(1'b1, 1'b0);
    collect(17, 0);
    release_result(1'b0);
    e32 = bus32.res[511:480];
    check("ident_b3_acc", e32, 6);

    set_mats(0, 1'b1, 1, 1'b0);
    accept(1'b0, 1'b0);
    collect(17, 0);
    release_result(1'b0);
    e32 = bus32.res[31:0];
    check("ident_b1", e32, 1);

    set_mats(255, 1'b0, 255, 1'b0);
    accept(1'b0, 1'b0);
    collect(17, 1);
    e16 = bus16.res[255:240];
    check("aw16_wrap", e16, 63492);
    check("aw16_ovf", bus16.ovf, 1);
    release_result(1'b1);

    set_mats(0, 1'b0, 0, 1'b1);
    accept(1'b0, 1'b0);
    collect(17, 0);
    release_result(1'b0);

    set_mats(0, 1'b0, 0, 1'b1);
    accept(1'b1, 1'b0);
    clear = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    clear = 1'b0;
    collect(12, 0);
    release_result(1'b0);

    set_mats(0, 1'b0, 0, 1'b1);
    accept(1'b1, 1'b0);
    repeat (6) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_zero();
    if (sb.size() > 0) void'(sb.pop_back());
    check("midrst_busy", bus32.busy, 0);
    check("midrst_in_ready", bus32.in_ready, 1);
    check("midrst_res32", bus32.res, 0);
    check("midrst_ovf16", bus16.ovf, 0);
    set_mats(0, 1'b0, 0, 1'b1);
    accept(1'b0, 1'b0);
    collect(17, 0);
    release_result(1'b0);

    set_mats(0, 1'b1, 3, 1'b0);
    accept(1'b1, 1'b1);
    collect(17, 0);
    release_result(1'b0);
    e32 = bus32.res[31:0];
    check("clr_accept_plain", e32, 3);

    for (int r = 0; r < 4; r++) begin
      set_mats(0, 1'b0, 0, 1'b1);
      accept(1'($urandom_range(0, 1)), 1'b0);
      collect(17, $urandom_range(0, 3));
      release_result(1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mmac_tile_engine.md
MMAC_TILE_ENGINE -- requirements
Module: mmac_tile_engine

Interface
REQ-001 Parameter N, default 4, matrix dimension (NxN), legal range 2..8.
REQ-002 Parameter DW, default 8, unsigned operand element width.
REQ-003 Parameter AW, default 32, accumulator element width; AW >= 2*DW.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 in_valid  in  1  operand pair present.
REQ-007 in_ready  out  1  engine accepts operands.
REQ-008 mat_a  in  N*N*DW  matrix A, row-major, element [i][k] at bits (i*N+k)*DW upward.
REQ-009 mat_b  in  N*N*DW  matrix B, same packing.
REQ-010 acc_mode  in  1  sampled with operands: 1 adds the product to the accumulators, 0 overwrites them.
REQ-011 clear  in  1  zeroes the accumulators and ovf.
REQ-012 out_valid  out  1  result available.
REQ-013 out_ready  in  1  consumer takes result.
REQ-014 res  out  N*N*AW  accumulator array, row-major, element [i][j] at bits (i*N+j)*AW upward.
REQ-015 busy  out  1  high in COMPUTE.
REQ-016 ovf  out  1  sticky accumulator overflow flag.

Function
REQ-017 The FSM SHALL have the states IDLE, COMPUTE and DONE.
REQ-018 in_ready SHALL be 1 only in IDLE.
REQ-019 On in_valid&&in_ready, the block SHALL register mat_a, mat_b and acc_mode, clear counters i=j=0, and enter COMPUTE.
REQ-020 Each COMPUTE cycle SHALL produce one element: acc[i][j] <= (acc_mode ? acc[i][j] : 0) + sum over k of A[i][k]*B[k][j], unsigned.
REQ-021 The counters SHALL advance row-major: j increments and wraps at N-1, and i increments on the j wrap.
REQ-022 After element [N-1][N-1], the FSM SHALL enter DONE.
REQ-023 Latency: out_valid SHALL rise exactly N*N+1 cycles after the accept edge (17 cycles at N=4).
REQ-024 Operand changes after the accept edge SHALL NOT affect the result.
REQ-025 Accumulation SHALL wrap modulo 2^AW.
REQ-026 ovf SHALL set when any element update (dot product plus prior value) exceeds 2^AW-1, and SHALL stay set until clear or reset.
REQ-027 out_valid SHALL be 1 only in DONE and SHALL hold until out_ready=1.
REQ-028 DONE with out_ready=1 SHALL return the FSM to IDLE the next cycle; there is no operand accept in that cycle.
REQ-029 res SHALL continuously reflect the accumulator registers, and SHALL be stable whenever out_valid=1.
REQ-030 clear in IDLE or DONE SHALL zero all accumulators and ovf on the next edge without changing the FSM state.
REQ-031 clear SHALL be ignored in COMPUTE.
REQ-032 clear together with an accept in IDLE: the clear SHALL apply first, so the new operation starts from zero accumulators regardless of acc_mode.
REQ-033 clear together with out_ready in DONE: both SHALL take effect (accumulators zeroed, FSM to IDLE).

Reset
REQ-034 While rst=0 at a rising edge, the FSM SHALL go to IDLE, all accumulators to 0, counters to 0 and ovf to 0.
REQ-035 Reset output values: in_ready=1, out_valid=0, busy=0, ovf=0, res=0.
REQ-036 Reset SHALL abort COMPUTE or DONE immediately with no partial result retained.

Verification
REQ-037 N=4, DW=8, AW=32; A=identity, B=all 3, acc_mode=0 -> out_valid at cycle 17 after accept, every res element 3, ovf=0.
REQ-038 Repeat the REQ-037 operands with acc_mode=1 -> every res element 6; then acc_mode=0 with B=all 1 -> every element 1.
REQ-039 AW=16; A=B=all 255, acc_mode=0 -> every element 260100 mod 65536 = 63492, ovf=1; then clear in DONE -> res=0, ovf=0.
REQ-040 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid held, in_ready=0, res unchanged; out_ready=1 -> IDLE next cycle.
REQ-041 Assert rst=0 at cycle 7 of COMPUTE -> next cycle busy=0, in_ready=1, res=0; a new operation then completes correctly.
REQ-042 Assert clear during COMPUTE -> ignored, result matches the expected value; clear with an accept and acc_mode=1 -> result equals the plain product.
